alu_result_fifo: RTL and testbench

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

---
 rtl/alu_result_fifo.sv | 112 +++++++++++
 tb/tb_alu_result_fifo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word-fall-through FIFO of ALU results.
// Each entry holds the 8-bit result plus {U,V,N,Z} flags, which are computed once at push time.
// sticky_v records any pushed overflow until it is cleared.
module alu_result_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [7:0]               in_a,
  input  logic [7:0]               in_b,
  input  logic [7:0]               in_res,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_res,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     sticky_v,
  input  logic                     clr_sticky
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  // Entry layout: {res[7:0], U, V, N, Z}
  logic [11:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          sticky_q, sticky_d;

  logic          push, pop;
  logic          flag_z, flag_n, flag_v, flag_u;
  logic [3:0]    in_flags;
  logic [11:0]   head;

  // Handshake: readiness depends only on stored occupancy, never on out_ready.
  always_comb begin
    in_ready  = (count_q < FullCount);
    out_valid = (count_q != '0);
    push      = in_valid && in_ready;
    pop       = out_ready && out_valid;
  end

  // Flag generation from the incoming ALU transaction.
  always_comb begin
    flag_z = (in_res == 8'd0);
    flag_n = in_res[7];
    flag_u = (in_op >= 3'b101);
    case (in_op)
      3'b000:  flag_v = (in_a[7] == in_b[7]) && (in_res[7] != in_a[7]);
      3'b001:  flag_v = (in_a[7] != in_b[7]) && (in_res[7] != in_a[7]);
      default: flag_v = 1'b0;
    endcase
    in_flags = {flag_u, flag_v, flag_n, flag_z};
  end

  // Next-state for pointers, occupancy and the sticky overflow bit.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A pushed overflow takes priority over a same-cycle clear.
    if (push && flag_v) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Control state; reset acts immediately so outputs drop without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

  // Storage array; contents are don't-care after reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {in_res, in_flags};
  end

  // Head presentation, forced to zero while empty.
  always_comb begin
    head      = mem_q[rptr_q];
    out_res   = out_valid ? head[11:4] : 8'd0;
    out_flags = out_valid ? head[3:0]  : 4'd0;
    count     = count_q;
    sticky_v  = sticky_q;
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Randomised and directed bench for alu_result_fifo with a queue-based reference model.
module tb_alu_result_fifo;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [7:0] in_a, in_b, in_res;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_res;
  logic [3:0] out_flags;
  logic [2:0] count;
  logic       sticky_v;
  logic       clr_sticky;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of {res, flags} and a sticky bit.
  logic [11:0] mq[$];
  bit          m_sticky;

  alu_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_res     (in_res),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_res    (out_res),
    .out_flags  (out_flags),
    .count      (count),
    .sticky_v   (sticky_v),
    .clr_sticky (clr_sticky)
  );

  always #5 clk = ~clk;

  // Flags from signed-value reasoning: overflow means the result sign contradicts the
  // sign the true sum/difference must have.
  function automatic logic [3:0] ref_flags(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] res);
    bit an, bn, rn, v, u;
    an = ($signed(a) < 0);
    bn = ($signed(b) < 0);
    rn = ($signed(res) < 0);
    v  = 1'b0;
    if (op == 3'd0) v = (an == bn) && (rn != an);
    if (op == 3'd1) v = (an != bn) && (rn != an);
    u  = (op > 3'd4);
    return {u, v, rn, (res == 8'd0)};
  endfunction

  // Drive one cycle's inputs at the falling edge, commit the model at the rising edge,
  // then settle 1ns so callers can compare.
  task automatic step(input bit v, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] res, input bit ordy,
                      input bit clr);
    bit do_push, do_pop;
    logic [3:0] f;
    @(negedge clk);
    in_valid = v; in_op = op; in_a = a; in_b = b; in_res = res;
    out_ready = ordy; clr_sticky = clr;
    @(posedge clk);
    f       = ref_flags(op, a, b, res);
    do_push = v && (mq.size() < DEPTH);
    do_pop  = ordy && (mq.size() > 0);
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back({res, f});
    if (do_push && f[2]) m_sticky = 1'b1;
    else if (clr) m_sticky = 1'b0;
    #1;
    in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_op = 0; in_a = 0; in_b = 0; in_res = 0; out_ready = 0; clr_sticky = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if ({out_res, out_flags, sticky_v} !== 13'd0) begin errors++;
      $display("FAIL reset_outputs got res=%h flags=%b sticky=%b exp all 0", out_res, out_flags, sticky_v); end
    @(negedge clk);
    rst = 1'b0;
    mq.delete(); m_sticky = 0;
  endtask

  task automatic test_basic_push();
    step(1, 3'b000, 8'd12, 8'hFC, 8'd8, 0, 0);
    checks++; if ({out_valid, out_res, out_flags, count} !== {1'b1, 8'd8, 4'b0000, 3'd1}) begin errors++;
      $display("FAIL basic_push got v=%b res=%0d flags=%b cnt=%0d exp v=1 res=8 flags=0000 cnt=1",
               out_valid, out_res, out_flags, count); end
    step(0, 0, 0, 0, 0, 1, 0);
    checks++; if ({out_valid, out_res, out_flags} !== 13'd0) begin errors++;
      $display("FAIL basic_pop got v=%b res=%h flags=%b exp 0", out_valid, out_res, out_flags); end
  endtask

  task automatic test_sticky();
    step(1, 3'b000, 8'd127, 8'd1, 8'h80, 0, 0);
    checks++; if (out_flags !== 4'b0110) begin errors++; $display("FAIL sticky_flags got=%b exp=0110", out_flags); end
    checks++; if (sticky_v !== 1'b1) begin errors++; $display("FAIL sticky_set got=%b exp=1", sticky_v); end
    step(1, 3'b001, 8'h80, 8'd1, 8'h7F, 0, 1);
    checks++; if (sticky_v !== 1'b1) begin errors++; $display("FAIL sticky_set_wins got=%b exp=1", sticky_v); end
    step(0, 0, 0, 0, 0, 0, 1);
    checks++; if (sticky_v !== 1'b0) begin errors++; $display("FAIL sticky_clear got=%b exp=0", sticky_v); end
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL sticky_drain got=%0d exp=0", count); end
  endtask

  task automatic test_flags_order();
    step(1, 3'b001, 8'd12, 8'd12, 8'd0, 0, 0);
    step(1, 3'b101, 8'h55, 8'hF0, 8'd0, 0, 0);
    checks++; if (out_flags !== 4'b0001) begin errors++; $display("FAIL flags_first got=%b exp=0001", out_flags); end
    step(0, 0, 0, 0, 0, 1, 0);
    checks++; if (out_flags !== 4'b1001 || out_valid !== 1'b1) begin errors++;
      $display("FAIL flags_second got=%b v=%b exp=1001 v=1", out_flags, out_valid); end
    step(0, 0, 0, 0, 0, 1, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flags_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_full();
    for (int i = 1; i <= 5; i++) begin
      step(1, 3'b010, 8'hFF, 8'hFF, 8'(i), 0, 0);
      if (i >= 4) begin
        checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin errors++;
          $display("FAIL full_hold push=%0d got cnt=%0d rdy=%b exp cnt=4 rdy=0", i, count, in_ready); end
      end
    end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_res !== 8'(i)) begin errors++;
        $display("FAIL full_drain got v=%b res=%0d exp v=1 res=%0d", out_valid, out_res, i); end
      step(0, 0, 0, 0, 0, 1, 0);
    end
    checks++; if (out_valid !== 1'b0 || out_res !== 8'd0) begin errors++;
      $display("FAIL full_empty got v=%b res=%0d exp v=0 res=0", out_valid, out_res); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_head;
    for (int i = 0; i < DEPTH; i++) step(1, 3'b011, 8'd0, 8'd0, 8'(8'h40 + i), 0, 0);
    step(1, 3'b000, 8'd1, 8'd1, 8'd2, 1, 0);
    checks++; if (count !== 3'd3 || in_ready !== 1'b1) begin errors++;
      $display("FAIL full_pushpop got cnt=%0d rdy=%b exp cnt=3 rdy=1", count, in_ready); end
    for (int i = 0; i < 200; i++) begin
      step($urandom_range(0, 1), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
           8'($urandom), $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
      exp_head = (mq.size() > 0) ? mq[0] : 12'd0;
      checks++;
      if ({out_res, out_flags} !== exp_head || out_valid !== (mq.size() > 0) ||
          count !== 3'(mq.size()) || in_ready !== (mq.size() < DEPTH) || sticky_v !== m_sticky) begin
        errors++;
        $display("FAIL random_cycle%0d got v=%b head=%h cnt=%0d rdy=%b st=%b exp v=%b head=%h cnt=%0d st=%b",
                 i, out_valid, {out_res, out_flags}, count, in_ready, sticky_v,
                 (mq.size() > 0), exp_head, mq.size(), m_sticky);
      end
    end
    while (mq.size() > 0) step(0, 0, 0, 0, 0, 1, 0);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL random_drain got=%0d exp=0", count); end
  endtask

  task automatic test_async_reset();
    step(1, 3'b000, 8'd127, 8'd1, 8'h80, 0, 0);
    step(1, 3'b010, 8'd0, 8'd0, 8'd7, 0, 0);
    step(1, 3'b010, 8'd0, 8'd0, 8'd9, 0, 0);
    checks++; if (count !== 3'd3 || sticky_v !== 1'b1) begin errors++;
      $display("FAIL arst_pre got cnt=%0d st=%b exp cnt=3 st=1", count, sticky_v); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({out_valid, count, sticky_v, out_res, out_flags} !== 17'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL arst_async got v=%b cnt=%0d st=%b res=%h rdy=%b exp 0,0,0,0,1",
               out_valid, count, sticky_v, out_res, in_ready); end
    #1;
    rst = 1'b0;
    mq.delete(); m_sticky = 0;
    step(1, 3'b011, 8'd0, 8'd0, 8'h3C, 0, 0);
    checks++; if (out_res !== 8'h3C || count !== 3'd1) begin errors++;
      $display("FAIL arst_new got res=%h cnt=%0d exp res=3c cnt=1", out_res, count); end
    step(0, 0, 0, 0, 0, 1, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_only_new got v=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic_push();
    test_sticky();
    test_flags_order();
    test_full();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
